id_fwd_stage: RTL and testbench

//  Parametrised decode/issue stage register for the pipelined CPU. Takes decoded fields from the decoder,

---
 rtl/id_fwd_stage.sv | 148 ++++++++++++++
 tb/tb_id_fwd_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_fwd_stage.sv
// Decode/issue stage register. It resolves source operands through an N-source forwarding network,
// detects load-use hazards against the ID register and a load scoreboard, and inserts bubbles on a hazard.
module id_fwd_stage #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 30,
  parameter int GPR_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int LD_LAT  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      if_en_i,
  input  logic [PC_W-1:0]           if_pc_i,
  input  logic [GPR_AW-1:0]         dec_ra_addr_i,
  input  logic                      dec_ra_used_i,
  input  logic [GPR_AW-1:0]         dec_rb_addr_i,
  input  logic                      dec_rb_used_i,
  input  logic [DATA_W-1:0]         gpr_ra_data_i,
  input  logic [DATA_W-1:0]         gpr_rb_data_i,
  input  logic [GPR_AW-1:0]         dec_dst_addr_i,
  input  logic                      dec_gpr_we_n_i,
  input  logic                      dec_is_ld_i,
  input  logic [NUM_FWD-1:0]        fwd_en_i,
  input  logic [NUM_FWD-1:0]        fwd_we_n_i,
  input  logic [NUM_FWD*GPR_AW-1:0] fwd_dst_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic                      ld_hazard_o,
  output logic                      id_en_o,
  output logic [PC_W-1:0]           id_pc_o,
  output logic [DATA_W-1:0]         id_ra_data_o,
  output logic [DATA_W-1:0]         id_rb_data_o,
  output logic [GPR_AW-1:0]         id_dst_addr_o,
  output logic                      id_gpr_we_n_o,
  output logic                      id_is_ld_o
);

  logic              id_en_q, id_we_n_q, id_is_ld_q;
  logic [PC_W-1:0]   id_pc_q;
  logic [DATA_W-1:0] id_ra_q, id_rb_q, ra_d, rb_d;
  logic [GPR_AW-1:0] id_dst_q;
  logic              id_load, ra_zero, rb_zero, sb_hit_a, sb_hit_b, ra_dep, rb_dep;

  // Youngest matching forwarding source wins. A non-load result still sitting in the ID register is
  // deliberately not forwarded: it has not been computed yet, so the GPR value is used instead.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [GPR_AW-1:0]         addr,
    input logic [DATA_W-1:0]         gpr,
    input logic [NUM_FWD-1:0]        en,
    input logic [NUM_FWD-1:0]        we_n,
    input logic [NUM_FWD*GPR_AW-1:0] dst,
    input logic [NUM_FWD*DATA_W-1:0] data
  );
    logic [DATA_W-1:0] res;
    logic              hit;
    res = gpr;
    hit = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && en[i] && !we_n[i] && dst[i*GPR_AW +: GPR_AW] == addr) begin
        res = data[i*DATA_W +: DATA_W];
        hit = 1'b1;
      end
    end
    if (ZERO_R0 != 0 && addr == '0) res = '0;
    return res;
  endfunction

  assign ra_d    = resolve(dec_ra_addr_i, gpr_ra_data_i, fwd_en_i, fwd_we_n_i, fwd_dst_i, fwd_data_i);
  assign rb_d    = resolve(dec_rb_addr_i, gpr_rb_data_i, fwd_en_i, fwd_we_n_i, fwd_dst_i, fwd_data_i);
  assign id_load = id_en_q & id_is_ld_q & ~id_we_n_q;
  assign ra_zero = (ZERO_R0 != 0) && (dec_ra_addr_i == '0);
  assign rb_zero = (ZERO_R0 != 0) && (dec_rb_addr_i == '0);

  // Only entries 0..LD_LAT-2 can still block a consumer, so the oldest entry is never stored.
  generate
    if (LD_LAT > 1) begin : g_sb
      localparam int SB_N = LD_LAT - 1;
      logic [SB_N-1:0]   vld_q;
      logic [GPR_AW-1:0] dst_q [SB_N];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          vld_q <= '0;
          for (int k = 0; k < SB_N; k++) dst_q[k] <= '0;
        end else if (!stall_i) begin
          vld_q[0] <= id_load;
          dst_q[0] <= id_dst_q;
          for (int k = 1; k < SB_N; k++) begin
            vld_q[k] <= vld_q[k-1];
            dst_q[k] <= dst_q[k-1];
          end
        end
      end

      always_comb begin
        sb_hit_a = 1'b0;
        sb_hit_b = 1'b0;
        for (int k = 0; k < SB_N; k++) begin
          if (vld_q[k] && dst_q[k] == dec_ra_addr_i) sb_hit_a = 1'b1;
          if (vld_q[k] && dst_q[k] == dec_rb_addr_i) sb_hit_b = 1'b1;
        end
      end
    end else begin : g_no_sb
      assign sb_hit_a = 1'b0;
      assign sb_hit_b = 1'b0;
    end
  endgenerate

  assign ra_dep = dec_ra_used_i & ~ra_zero & ((id_load & (id_dst_q == dec_ra_addr_i)) | sb_hit_a);
  assign rb_dep = dec_rb_used_i & ~rb_zero & ((id_load & (id_dst_q == dec_rb_addr_i)) | sb_hit_b);
  assign ld_hazard_o = if_en_i & (ra_dep | rb_dep);

  // Priority: flush, then stall (hold everything), then hazard bubble, then normal issue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_en_q    <= 1'b0;
      id_pc_q    <= '0;
      id_ra_q    <= '0;
      id_rb_q    <= '0;
      id_dst_q   <= '0;
      id_we_n_q  <= 1'b1;
      id_is_ld_q <= 1'b0;
    end else if (flush_i || (!stall_i && ld_hazard_o)) begin
      id_en_q    <= 1'b0;
      id_we_n_q  <= 1'b1;
      id_is_ld_q <= 1'b0;
    end else if (!stall_i) begin
      id_en_q    <= if_en_i;
      id_pc_q    <= if_pc_i;
      id_ra_q    <= ra_d;
      id_rb_q    <= rb_d;
      id_dst_q   <= dec_dst_addr_i;
      id_we_n_q  <= dec_gpr_we_n_i | ~if_en_i;
      id_is_ld_q <= dec_is_ld_i & if_en_i;
    end
  end

  assign id_en_o       = id_en_q;
  assign id_pc_o       = id_pc_q;
  assign id_ra_data_o  = id_ra_q;
  assign id_rb_data_o  = id_rb_q;
  assign id_dst_addr_o = id_dst_q;
  assign id_gpr_we_n_o = id_we_n_q;
  assign id_is_ld_o    = id_is_ld_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage: two instances share stimulus, one with LD_LAT=1 and one with LD_LAT=2.
module tb_id_fwd_stage;

  logic        clk, rst;
  logic        ifEn, raUsed, rbUsed, weN, isLd, stall, flush;
  logic [29:0] ifPc;
  logic [4:0]  raAddr, rbAddr, dstAddr;
  logic [31:0] gprRa, gprRb;
  logic [1:0]  fwdEn, fwdWeN;
  logic [9:0]  fwdDst;
  logic [63:0] fwdData;

  logic        hz1, en1, we1, ld1, hz2, en2, we2, ld2;
  logic [29:0] pc1, pc2;
  logic [31:0] ra1, rb1, ra2, rb2;
  logic [4:0]  dst1, dst2;

  int checkCount = 0;
  int passCount  = 0;

  id_fwd_stage #(.DATA_W(32), .PC_W(30), .GPR_AW(5), .NUM_FWD(2), .LD_LAT(1), .ZERO_R0(1)) uLat1 (
    .clk_i(clk), .rst_i(rst), .if_en_i(ifEn), .if_pc_i(ifPc),
    .dec_ra_addr_i(raAddr), .dec_ra_used_i(raUsed), .dec_rb_addr_i(rbAddr), .dec_rb_used_i(rbUsed),
    .gpr_ra_data_i(gprRa), .gpr_rb_data_i(gprRb), .dec_dst_addr_i(dstAddr), .dec_gpr_we_n_i(weN),
    .dec_is_ld_i(isLd), .fwd_en_i(fwdEn), .fwd_we_n_i(fwdWeN), .fwd_dst_i(fwdDst), .fwd_data_i(fwdData),
    .stall_i(stall), .flush_i(flush), .ld_hazard_o(hz1), .id_en_o(en1), .id_pc_o(pc1),
    .id_ra_data_o(ra1), .id_rb_data_o(rb1), .id_dst_addr_o(dst1), .id_gpr_we_n_o(we1), .id_is_ld_o(ld1)
  );

  id_fwd_stage #(.DATA_W(32), .PC_W(30), .GPR_AW(5), .NUM_FWD(2), .LD_LAT(2), .ZERO_R0(1)) uLat2 (
    .clk_i(clk), .rst_i(rst), .if_en_i(ifEn), .if_pc_i(ifPc),
    .dec_ra_addr_i(raAddr), .dec_ra_used_i(raUsed), .dec_rb_addr_i(rbAddr), .dec_rb_used_i(rbUsed),
    .gpr_ra_data_i(gprRa), .gpr_rb_data_i(gprRb), .dec_dst_addr_i(dstAddr), .dec_gpr_we_n_i(weN),
    .dec_is_ld_i(isLd), .fwd_en_i(fwdEn), .fwd_we_n_i(fwdWeN), .fwd_dst_i(fwdDst), .fwd_data_i(fwdData),
    .stall_i(stall), .flush_i(flush), .ld_hazard_o(hz2), .id_en_o(en2), .id_pc_o(pc2),
    .id_ra_data_o(ra2), .id_rb_data_o(rb2), .id_dst_addr_o(dst2), .id_gpr_we_n_o(we2), .id_is_ld_o(ld2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic en, input logic [29:0] pc, input logic [4:0] ra, input logic raU,
                               input logic [4:0] rb, input logic rbU, input logic [4:0] dst,
                               input logic wen, input logic ld);
    ifEn = en; ifPc = pc; raAddr = ra; raUsed = raU; rbAddr = rb; rbUsed = rbU;
    dstAddr = dst; weN = wen; isLd = ld;
  endtask

  // Inputs change 1 time unit after each rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    applyStimulus(1'b0, 30'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    gprRa = '0; gprRb = '0; fwdEn = 2'b00; fwdWeN = 2'b11; fwdDst = '0; fwdData = '0;
    step();
    step();
    checkOutput("rst_en", 32'(en1), 32'd0);
    checkOutput("rst_we_n", 32'(we1), 32'd1);
    checkOutput("rst_is_ld", 32'(ld1), 32'd0);
    checkOutput("rst_pc", 32'(pc1), 32'd0);
    checkOutput("rst_ra", ra1, 32'd0);
    checkOutput("rst_hazard", 32'(hz1), 32'd0);
    rst = 1'b0;

    // Forwarding priority: EX beats MEM beats GPR.
    applyStimulus(1'b1, 30'h100, 5'd3, 1'b1, 5'd5, 1'b1, 5'd7, 1'b0, 1'b0);
    fwdEn = 2'b11; fwdWeN = 2'b00; fwdDst = {5'd3, 5'd3}; fwdData = {32'hBBBB, 32'hAAAA};
    gprRa = 32'hCCCC; gprRb = 32'h5555;
    step();
    checkOutput("fwd0_wins", ra1, 32'hAAAA);
    checkOutput("rb_from_gpr", rb1, 32'h5555);
    checkOutput("issue_en", 32'(en1), 32'd1);
    checkOutput("issue_pc", 32'(pc1), 32'h100);
    checkOutput("issue_dst", 32'(dst1), 32'd7);
    checkOutput("issue_we_n", 32'(we1), 32'd0);
    fwdEn = 2'b10;
    step();
    checkOutput("fwd1_wins", ra1, 32'hBBBB);
    fwdEn = 2'b11; fwdWeN = 2'b11;
    step();
    checkOutput("gpr_fallback", ra1, 32'hCCCC);

    // r0 reads as zero, is never forwarded and never hazards.
    applyStimulus(1'b1, 30'h104, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
    fwdEn = 2'b01; fwdWeN = 2'b10; fwdDst = {5'd3, 5'd0}; fwdData = {32'hBBBB, 32'hFFFF}; gprRa = 32'h7777;
    step();
    checkOutput("r0_zero", ra1, 32'd0);
    applyStimulus(1'b1, 30'h108, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, 30'h10C, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b0, 1'b0);
    #1;
    checkOutput("r0_no_hz_l1", 32'(hz1), 32'd0);
    checkOutput("r0_no_hz_l2", 32'(hz2), 32'd0);
    step();
    checkOutput("r0_issue", 32'(en1), 32'd1);

    // Load immediately followed by a consumer.
    fwdEn = 2'b00; fwdWeN = 2'b11;
    applyStimulus(1'b1, 30'h110, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, 30'h114, 5'd4, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0);
    #1;
    checkOutput("lu_hz_l1", 32'(hz1), 32'd1);
    checkOutput("lu_hz_l2", 32'(hz2), 32'd1);
    step();
    checkOutput("lu_bubble_en", 32'(en1), 32'd0);
    checkOutput("lu_bubble_we_n", 32'(we1), 32'd1);
    checkOutput("lu_hz_clear_l1", 32'(hz1), 32'd0);
    checkOutput("lu_hz_still_l2", 32'(hz2), 32'd1);
    fwdEn = 2'b10; fwdWeN = 2'b01; fwdDst = {5'd4, 5'd0}; fwdData = {32'h1234, 32'h0}; gprRa = 32'hDEAD;
    step();
    checkOutput("lu_issue_l1", 32'(en1), 32'd1);
    checkOutput("lu_data_l1", ra1, 32'h1234);
    checkOutput("lu_pc_l1", 32'(pc1), 32'h114);
    checkOutput("lu_bubble2_l2", 32'(en2), 32'd0);
    checkOutput("lu_hz_clear_l2", 32'(hz2), 32'd0);
    step();
    checkOutput("lu_issue_l2", 32'(en2), 32'd1);
    checkOutput("lu_data_l2", ra2, 32'h1234);

    // Load, independent insn, consumer: one bubble only for LD_LAT=2.
    applyStimulus(1'b1, 30'h120, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, 30'h124, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    #1;
    checkOutput("gap_nop_hz_l2", 32'(hz2), 32'd0);
    step();
    applyStimulus(1'b1, 30'h128, 5'd4, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0);
    #1;
    checkOutput("gap_hz_l1", 32'(hz1), 32'd0);
    checkOutput("gap_hz_l2", 32'(hz2), 32'd1);
    step();
    checkOutput("gap_bubble_l2", 32'(en2), 32'd0);
    checkOutput("gap_hz_clear_l2", 32'(hz2), 32'd0);
    step();
    checkOutput("gap_issue_l2", 32'(en2), 32'd1);
    checkOutput("gap_pc_l2", 32'(pc2), 32'h128);

    // Stall holds, flush beats stall.
    applyStimulus(1'b1, 30'h200, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0);
    step();
    checkOutput("ctl_pc", 32'(pc1), 32'h200);
    stall = 1'b1;
    applyStimulus(1'b1, 30'h204, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0);
    repeat (3) step();
    checkOutput("stall_pc", 32'(pc1), 32'h200);
    checkOutput("stall_dst", 32'(dst1), 32'd6);
    checkOutput("stall_en", 32'(en1), 32'd1);
    flush = 1'b1;
    step();
    checkOutput("flush_stall_en", 32'(en1), 32'd0);
    checkOutput("flush_stall_we_n", 32'(we1), 32'd1);
    flush = 1'b0; stall = 1'b0;
    step();
    checkOutput("resume_en", 32'(en1), 32'd1);
    checkOutput("resume_pc", 32'(pc1), 32'h204);

    // Reset in the middle of a stalled hazard clears ID and scoreboard.
    applyStimulus(1'b1, 30'h208, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, 30'h20C, 5'd4, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0);
    step();
    stall = 1'b1;
    #1;
    checkOutput("pre_rst_hz_l2", 32'(hz2), 32'd1);
    rst = 1'b1;
    #1;
    ifEn = 1'b0;
    #1;
    checkOutput("mid_rst_en", 32'(en1), 32'd0);
    checkOutput("mid_rst_we_n", 32'(we1), 32'd1);
    checkOutput("mid_rst_is_ld", 32'(ld1), 32'd0);
    checkOutput("mid_rst_pc", 32'(pc1), 32'd0);
    checkOutput("mid_rst_hz_l1", 32'(hz1), 32'd0);
    checkOutput("mid_rst_hz_l2", 32'(hz2), 32'd0);
    rst = 1'b0; stall = 1'b0; ifEn = 1'b1;
    #1;
    checkOutput("post_rst_sb_l2", 32'(hz2), 32'd0);
    step();
    checkOutput("post_rst_issue", 32'(en2), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
